// File: rtl/fusion_pkg.sv
// Shared encodings and saturation helper for the fusion stream core.
package fusion_pkg;

  localparam logic [1:0] MODE_SAVG = 2'd0;
  localparam logic [1:0] MODE_EMA  = 2'd1;
  localparam logic [1:0] MODE_PASS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Clamp a signed value into the unsigned range [0, 2^width-1].
  function automatic logic signed [31:0] clamp_u(input logic signed [31:0] value,
                                                 input int width);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< width) - 32'sd1;
    if (value < 32'sd0) begin
      return 32'sd0;
    end
    if (value > max_v) begin
      return max_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/fusion_lane_alu.sv
// One-pixel datapath: S2 forms the rounded signed sums, S3 shifts, clamps and
// registers the new averaged and fused pixels. Both stages advance on en.
module fusion_lane_alu
  import fusion_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int FUSE_SHIFT        = 3
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] avg_px,
  input  logic [DATA_WIDTH-1:0] new_px,
  input  logic [DATA_WIDTH-1:0] fused_px,
  input  logic [DATA_WIDTH-1:0] old_px,
  output logic [DATA_WIDTH-1:0] new_avg,
  output logic [DATA_WIDTH-1:0] new_fused
);

  localparam int AW = DATA_WIDTH + LOG2_NO_OF_IMAGES + 2;
  localparam int FW = DATA_WIDTH + FUSE_SHIFT + 2;
  localparam logic signed [AW-1:0] RND_A = AW'(2 ** (LOG2_NO_OF_IMAGES - 1));
  localparam logic signed [FW-1:0] RND_F = FW'(2 ** (FUSE_SHIFT - 1));

  function automatic logic signed [AW-1:0] ext_a(input logic [DATA_WIDTH-1:0] x);
    return signed'(AW'(x));
  endfunction

  function automatic logic signed [FW-1:0] ext_f(input logic [DATA_WIDTH-1:0] x);
    return signed'(FW'(x));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_a(input logic signed [AW-1:0] v);
    return DATA_WIDTH'(clamp_u(32'(v), DATA_WIDTH));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_f(input logic signed [FW-1:0] v);
    return DATA_WIDTH'(clamp_u(32'(v), DATA_WIDTH));
  endfunction

  logic signed [AW-1:0]   sum_a_p2_q, sum_a_p2_d;
  logic signed [FW-1:0]   sum_f_p2_q, sum_f_p2_d;
  logic [DATA_WIDTH-1:0]  avg_p2_q, avg_p2_d;
  logic [DATA_WIDTH-1:0]  fused_p2_q, fused_p2_d;
  logic [1:0]             mode_p2_q, mode_p2_d;
  logic [DATA_WIDTH-1:0]  new_avg_p3_q, new_avg_p3_d;
  logic [DATA_WIDTH-1:0]  new_fused_p3_q, new_fused_p3_d;
  logic [DATA_WIDTH-1:0]  fused_upd;

  // ---- S2: rounded signed sums; avg/fused carried for the S3 add-back ----
  always_comb begin
    sum_a_p2_d = sum_a_p2_q;
    sum_f_p2_d = sum_f_p2_q;
    avg_p2_d   = avg_p2_q;
    fused_p2_d = fused_p2_q;
    mode_p2_d  = mode_p2_q;
    if (en) begin
      case (mode)
        MODE_SAVG: sum_a_p2_d = (ext_a(avg_px) <<< LOG2_NO_OF_IMAGES) + ext_a(new_px)
                                - ext_a(old_px) + RND_A;
        MODE_EMA:  sum_a_p2_d = ext_a(new_px) - ext_a(avg_px) + RND_A;
        default:   sum_a_p2_d = '0;
      endcase
      sum_f_p2_d = ext_f(new_px) - ext_f(fused_px) + RND_F;
      avg_p2_d   = avg_px;
      fused_p2_d = fused_px;
      mode_p2_d  = mode;
    end
  end

  // S2 register, no reset: contents are qualified by the valid sideband.
  always_ff @(posedge clk) begin
    sum_a_p2_q <= sum_a_p2_d;
    sum_f_p2_q <= sum_f_p2_d;
    avg_p2_q   <= avg_p2_d;
    fused_p2_q <= fused_p2_d;
    mode_p2_q  <= mode_p2_d;
  end

  // ---- S3: arithmetic shift, add-back, clamp ----
  assign fused_upd = sat_f(ext_f(fused_p2_q) + (sum_f_p2_q >>> FUSE_SHIFT));

  always_comb begin
    new_avg_p3_d   = new_avg_p3_q;
    new_fused_p3_d = new_fused_p3_q;
    if (en) begin
      case (mode_p2_q)
        MODE_SAVG: begin
          new_avg_p3_d   = sat_a(sum_a_p2_q >>> LOG2_NO_OF_IMAGES);
          new_fused_p3_d = fused_upd;
        end
        MODE_EMA: begin
          new_avg_p3_d   = sat_a(ext_a(avg_p2_q) + (sum_a_p2_q >>> LOG2_NO_OF_IMAGES));
          new_fused_p3_d = fused_upd;
        end
        default: begin
          new_avg_p3_d   = avg_p2_q;
          new_fused_p3_d = fused_p2_q;
        end
      endcase
    end
  end

  // S3 register; holds while the output is stalled.
  always_ff @(posedge clk) begin
    new_avg_p3_q   <= new_avg_p3_d;
    new_fused_p3_q <= new_fused_p3_d;
  end

  assign new_avg   = new_avg_p3_q;
  assign new_fused = new_fused_p3_q;

endmodule

// File: rtl/fusion_stream_core.sv
// AXI-Stream running-average / fused-image core, LANES pixels per beat.
// Three-stage stall-able pipeline, counter-based framing, tlast checking.
module fusion_stream_core
  import fusion_pkg::*;
#(
  parameter int IM_LEN            = 520,
  parameter int IM_WID            = 520,
  parameter int DATA_WIDTH        = 8,
  parameter int LANES             = 4,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int FUSE_SHIFT        = 3,
  parameter int BEAT_CNT_W        = 20
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset,
  input  logic [LANES*4*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [LANES*2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [1:0]                    cfg_mode,
  input  logic                          cfg_err_clr,
  output logic                          frame_done,
  output logic                          frame_err
);

  localparam int FRAME_BEATS = IM_LEN * IM_WID / LANES;
  localparam int IN_W        = LANES * 4 * DATA_WIDTH;
  localparam logic [BEAT_CNT_W-1:0] LAST_IDX = BEAT_CNT_W'(FRAME_BEATS - 1);

  state_e                state_q, state_d;
  logic [BEAT_CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic                  frame_err_q, frame_err_d;
  logic                  vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
  logic                  last_p1_q, last_p1_d, last_p2_q, last_p2_d, last_p3_q, last_p3_d;
  logic [IN_W-1:0]       tdata_p1_q, tdata_p1_d;
  logic [1:0]            mode_p1_q, mode_p1_d;

  logic       en;
  logic       accept;
  logic       last_beat;
  logic       out_hs;
  logic [1:0] mode_in;

  assign en            = !vld_p3_q || m_axis_tready;
  assign s_axis_tready = !axi_reset && en && (state_q != ST_DRAIN);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (in_cnt_q == LAST_IDX);
  assign out_hs        = vld_p3_q && m_axis_tready;
  // Reserved mode 3 behaves as passthrough.
  assign mode_in       = (cfg_mode == 2'd3) ? MODE_PASS : cfg_mode;

  // Frame FSM: mode latched on the first beat, DRAIN until output tlast handshake.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d  = mode_in;
          state_d = last_beat ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_hs && last_p3_q) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat counter and sticky tlast-mismatch flag (set wins over clear).
  always_comb begin
    in_cnt_d = in_cnt_q;
    if (accept) begin
      in_cnt_d = last_beat ? '0 : in_cnt_q + BEAT_CNT_W'(1);
    end
    frame_err_d = frame_err_q;
    if (cfg_err_clr) begin
      frame_err_d = 1'b0;
    end
    if (accept && (s_axis_tlast != last_beat)) begin
      frame_err_d = 1'b1;
    end
  end

  // Valid and last sideband; every stage moves on en, bubbles included.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    vld_p2_d  = vld_p2_q;
    vld_p3_d  = vld_p3_q;
    last_p1_d = last_p1_q;
    last_p2_d = last_p2_q;
    last_p3_d = last_p3_q;
    if (en) begin
      vld_p1_d  = accept;
      vld_p2_d  = vld_p1_q;
      vld_p3_d  = vld_p2_q;
      last_p1_d = accept && last_beat;
      last_p2_d = last_p1_q;
      last_p3_d = last_p2_q;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      mode_q      <= MODE_SAVG;
      frame_err_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      last_p2_q   <= 1'b0;
      last_p3_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      mode_q      <= mode_d;
      frame_err_q <= frame_err_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      last_p1_q   <= last_p1_d;
      last_p2_q   <= last_p2_d;
      last_p3_q   <= last_p3_d;
    end
  end

  // ---- S1: capture input beat and its effective mode ----
  always_comb begin
    tdata_p1_d = tdata_p1_q;
    mode_p1_d  = mode_p1_q;
    if (en) begin
      tdata_p1_d = s_axis_tdata;
      mode_p1_d  = (state_q == ST_IDLE) ? mode_in : mode_q;
    end
  end

  // S1 data register, no reset: qualified by vld_p1_q.
  always_ff @(posedge axi_clk) begin
    tdata_p1_q <= tdata_p1_d;
    mode_p1_q  <= mode_p1_d;
  end

  // ---- S2/S3: per-lane arithmetic ----
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fusion_lane_alu #(
      .DATA_WIDTH       (DATA_WIDTH),
      .LOG2_NO_OF_IMAGES(LOG2_NO_OF_IMAGES),
      .FUSE_SHIFT       (FUSE_SHIFT)
    ) u_alu (
      .clk      (axi_clk),
      .en       (en),
      .mode     (mode_p1_q),
      .avg_px   (tdata_p1_q[(4*k+0)*DATA_WIDTH +: DATA_WIDTH]),
      .new_px   (tdata_p1_q[(4*k+1)*DATA_WIDTH +: DATA_WIDTH]),
      .fused_px (tdata_p1_q[(4*k+2)*DATA_WIDTH +: DATA_WIDTH]),
      .old_px   (tdata_p1_q[(4*k+3)*DATA_WIDTH +: DATA_WIDTH]),
      .new_avg  (m_axis_tdata[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]),
      .new_fused(m_axis_tdata[(2*k+0)*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign m_axis_tvalid = vld_p3_q;
  assign m_axis_tlast  = last_p3_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_fusion_stream_core.sv
// Directed bench for fusion_stream_core: LANES=1, 2x2 image (4 beats/frame).
module tb_fusion_stream_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [1:0]  cfg_mode;
  logic        cfg_err_clr;
  logic        frame_done;
  logic        frame_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  logic [16:0] out_q[$];   // {tlast, new_avg, new_fused}
  logic [32:0] beat_q[$];  // {tlast, old, fused, new, avg}

  always #5 clk = ~clk;

  fusion_stream_core #(
    .IM_LEN(2), .IM_WID(2), .DATA_WIDTH(8), .LANES(1),
    .LOG2_NO_OF_IMAGES(4), .FUSE_SHIFT(3), .BEAT_CNT_W(20)
  ) dut (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .cfg_mode(cfg_mode), .cfg_err_clr(cfg_err_clr),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // Output collector: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [32:0] bt(input logic [7:0] a, n, f, o, input logic l);
    return {l, o, f, n, a};
  endfunction

  task automatic send_all(input logic [1:0] m_first, input logic [1:0] m_rest);
    bit ok;
    cfg_mode = m_first;
    for (int i = 0; i < beat_q.size(); i++) begin
      s_tvalid = 1'b1;
      {s_tlast, s_tdata} = beat_q[i];
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        @(negedge clk);
        if (s_tready) ok = 1'b1;
      end
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL accept_beat%0d: s_axis_tready=0 required 1 within 64 cycles", i);
        break;
      end
      @(posedge clk); #1;
      cfg_mode = m_rest;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    beat_q.delete();
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 200 && out_q.size() < n; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_q.size() != n) begin
      tests_failed++;
      $display("FAIL out_count: got %0d beats required %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    m_tready = 1'b1; cfg_mode = 2'd0; cfg_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run += 5;
    if (s_tready !== 1'b0)   begin tests_failed++; $display("FAIL rst_s_tready: got %b required 0", s_tready); end
    if (m_tvalid !== 1'b0)   begin tests_failed++; $display("FAIL rst_m_tvalid: got %b required 0", m_tvalid); end
    if (m_tlast !== 1'b0)    begin tests_failed++; $display("FAIL rst_m_tlast: got %b required 0", m_tlast); end
    if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    if (frame_err !== 1'b0)  begin tests_failed++; $display("FAIL rst_frame_err: got %b required 0", frame_err); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (s_tready !== 1'b1) begin tests_failed++; $display("FAIL idle_s_tready: got %b required 1", s_tready); end
  endtask

  task automatic test_mode0_basic();
    out_q.delete(); done_cnt = 0; cfg_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = {8'd40, 8'd50, 8'd120, 8'd100}; s_tlast = (i == 3);
      @(posedge clk); #1;
      if (i < 2) begin
        tests_run++;
        if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL latency_early%0d: m_tvalid=%b required 0", i, m_tvalid); end
      end
      if (i == 2) begin
        tests_run += 3;
        if (m_tvalid !== 1'b1) begin tests_failed++; $display("FAIL latency_first: m_tvalid=%b required 1", m_tvalid); end
        if (m_tdata !== {8'd105, 8'd59}) begin tests_failed++; $display("FAIL first_data: got %h required %h", m_tdata, {8'd105, 8'd59}); end
        if (m_tlast !== 1'b0) begin tests_failed++; $display("FAIL first_tlast: got %b required 0", m_tlast); end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== {(i == 3), 8'd105, 8'd59}) begin
        tests_failed++; $display("FAIL mode0_beat%0d: got %h required %h", i, out_q[i], {(i == 3), 8'd105, 8'd59});
      end
    end
    tests_run += 2;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL mode0_done: got %0d pulses required 1", done_cnt); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL mode0_err: got %b required 0", frame_err); end
  endtask

  task automatic test_clamp();
    logic [16:0] exp_v[4];
    exp_v = '{{1'b0, 8'd0, 8'd0}, {1'b0, 8'd255, 8'd255}, {1'b0, 8'd16, 8'd32}, {1'b1, 8'd239, 8'd223}};
    out_q.delete(); done_cnt = 0;
    beat_q.push_back(bt(8'd0,   8'd0,   8'd0,   8'd255, 1'b0));
    beat_q.push_back(bt(8'd255, 8'd255, 8'd255, 8'd0,   1'b0));
    beat_q.push_back(bt(8'd0,   8'd255, 8'd0,   8'd0,   1'b0));
    beat_q.push_back(bt(8'd255, 8'd0,   8'd255, 8'd255, 1'b1));
    send_all(2'd0, 2'd0);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== exp_v[i]) begin
        tests_failed++; $display("FAIL clamp_beat%0d: got %h required %h", i, out_q[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_v[4];
    logic [15:0] held;
    exp_v = '{{1'b0, 8'd105, 8'd59}, {1'b0, 8'd12, 8'd21}, {1'b0, 8'd197, 8'd100}, {1'b1, 8'd50, 8'd15}};
    out_q.delete(); done_cnt = 0;
    beat_q.push_back(bt(8'd100, 8'd120, 8'd50,  8'd40,  1'b0));
    beat_q.push_back(bt(8'd10,  8'd30,  8'd20,  8'd0,   1'b0));
    beat_q.push_back(bt(8'd200, 8'd100, 8'd100, 8'd150, 1'b0));
    beat_q.push_back(bt(8'd50,  8'd50,  8'd10,  8'd50,  1'b1));
    fork
      send_all(2'd0, 2'd0);
      begin
        for (int t = 0; t < 50; t++) begin
          @(posedge clk); #1;
          if (m_tvalid) break;
        end
        m_tready = 1'b0;
        #1;
        held = m_tdata;
        tests_run += 2;
        if (held !== {8'd105, 8'd59}) begin tests_failed++; $display("FAIL stall_head: got %h required %h", held, {8'd105, 8'd59}); end
        if (s_tready !== 1'b0) begin tests_failed++; $display("FAIL stall_s_tready: got %b required 0", s_tready); end
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          tests_run++;
          if (m_tdata !== held || m_tvalid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_hold%0d: got %h/%b required %h/1", c, m_tdata, m_tvalid, held);
          end
        end
        m_tready = 1'b1;
      end
    join
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== exp_v[i]) begin
        tests_failed++; $display("FAIL bp_beat%0d: got %h required %h", i, out_q[i], exp_v[i]);
      end
    end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_tlast_err();
    out_q.delete(); done_cnt = 0;
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_pre: got %b required 0", frame_err); end
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, (i == 1) || (i == 3)));
    send_all(2'd0, 2'd0);
    wait_out(4);
    tests_run += 2;
    if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL err_early_tlast: got %b required 1", frame_err); end
    if (done_cnt != 1) begin tests_failed++; $display("FAIL err_done: got %0d pulses required 1", done_cnt); end
    if (out_q.size() == 4) begin
      tests_run += 2;
      if (out_q[1][16] !== 1'b0) begin tests_failed++; $display("FAIL err_tlast_b1: got %b required 0", out_q[1][16]); end
      if (out_q[3][16] !== 1'b1) begin tests_failed++; $display("FAIL err_tlast_b3: got %b required 1", out_q[3][16]); end
    end
    cfg_err_clr = 1'b1; @(posedge clk); #1; cfg_err_clr = 1'b0;
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b required 0", frame_err); end
    // Missing tlast on the final beat.
    out_q.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, 1'b0));
    send_all(2'd0, 2'd0);
    wait_out(4);
    tests_run += 2;
    if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL err_missing_tlast: got %b required 1", frame_err); end
    if (done_cnt != 1) begin tests_failed++; $display("FAIL err2_done: got %0d pulses required 1", done_cnt); end
    cfg_err_clr = 1'b1; @(posedge clk); #1; cfg_err_clr = 1'b0;
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL err_clear2: got %b required 0", frame_err); end
  endtask

  task automatic test_mode_switch();
    out_q.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, i == 3));
    send_all(2'd0, 2'd1);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i][15:0] !== {8'd105, 8'd59}) begin
        tests_failed++; $display("FAIL switch_f1_beat%0d: got %h required %h", i, out_q[i][15:0], {8'd105, 8'd59});
      end
    end
    out_q.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, i == 3));
    send_all(2'd1, 2'd1);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== {(i == 3), 8'd101, 8'd59}) begin
        tests_failed++; $display("FAIL switch_f2_beat%0d: got %h required %h", i, out_q[i], {(i == 3), 8'd101, 8'd59});
      end
    end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL switch_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_reset_in_drain();
    out_q.delete(); done_cnt = 0;
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, i == 3));
    send_all(2'd0, 2'd0);
    @(posedge clk); #1;
    tests_run++;
    if (m_tvalid !== 1'b1) begin tests_failed++; $display("FAIL drain_inflight: m_tvalid=%b required 1", m_tvalid); end
    rst = 1'b1;
    #1;
    tests_run += 3;
    if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL drain_rst_tvalid: got %b required 0", m_tvalid); end
    if (m_tlast !== 1'b0)  begin tests_failed++; $display("FAIL drain_rst_tlast: got %b required 0", m_tlast); end
    if (s_tready !== 1'b0) begin tests_failed++; $display("FAIL drain_rst_tready: got %b required 0", s_tready); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete(); done_cnt = 0;
    @(posedge clk); #1;
    tests_run++;
    if (s_tready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_idle: s_tready=%b required 1", s_tready); end
    for (int i = 0; i < 4; i++) beat_q.push_back(bt(8'd100, 8'd120, 8'd50, 8'd40, i == 3));
    send_all(2'd1, 2'd1);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== {(i == 3), 8'd101, 8'd59}) begin
        tests_failed++; $display("FAIL post_rst_beat%0d: got %h required %h", i, out_q[i], {(i == 3), 8'd101, 8'd59});
      end
    end
    tests_run += 2;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL post_rst_done: got %0d pulses required 1", done_cnt); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL post_rst_err: got %b required 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_clamp();
    test_backpressure();
    test_tlast_err();
    test_mode_switch();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fusion_stream_core.md
Name: fusion_stream_core

Overview:
- Parametrised successor to the single-pixel fusion top: AXI-Stream front end for the running-average / fused-image update, generalised to LANES pixels per beat, runtime mode select and frame framing.
- Adds full output backpressure through a stall-able valid pipeline, counter-generated m_axis_tlast, input-tlast checking and per-frame status.
- Sits between the input DMA stream (packed avg/new/fused/old pixels) and the output DMA stream (packed new_avg/new_fused).

Parameters:
- IM_LEN, 520, pixels per line
- IM_WID, 520, lines per frame
- DATA_WIDTH, 8, bits per pixel field
- LANES, 4, pixels per beat; IM_LEN*IM_WID must be divisible by LANES
- LOG2_NO_OF_IMAGES, 4, averaging depth exponent (N = 2^LOG2)
- FUSE_SHIFT, 3, fused-channel EMA shift
- BEAT_CNT_W, 20, beat counter width; must satisfy 2^BEAT_CNT_W > FRAME_BEATS

Ports:
- axi_clk  in  1  clock
- axi_reset  in  1  asynchronous active-high reset
- s_axis_tdata  in  LANES*4*DATA_WIDTH  per lane k, LSB first: avg, new, fused, old
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  upstream end-of-frame marker; checked only
- m_axis_tdata  out  LANES*2*DATA_WIDTH  per lane k, LSB first: new_fused, new_avg
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat of frame
- cfg_mode  in  2  0 = sliding average, 1 = EMA average, 2 = passthrough, 3 = reserved (treated as 2)
- cfg_err_clr  in  1  clears frame_err
- frame_done  out  1  one-cycle pulse on output tlast handshake
- frame_err  out  1  sticky tlast-mismatch flag

Behaviour:
- FRAME_BEATS = IM_LEN*IM_WID/LANES (localparam).
- Reset (async assert, sync release): state = IDLE; all valid bits, counters and outputs = 0. s_axis_tready = 0 during reset.
- Pipeline: 3 stages S1/S2/S3, all advancing on en = !v3 | m_axis_tready. Bubbles are not collapsed. Latency is 3 cycles from accept to m_axis_tvalid when unstalled. Throughput is 1 beat/cycle.
- m_axis_tvalid = v3. m_axis_tdata and m_axis_tlast hold stable while v3 && !m_axis_tready.
- Accept = s_axis_tvalid && s_axis_tready. Beat counter in_cnt increments on accept and resets to 0 on the last beat. The last flag (in_cnt == FRAME_BEATS-1) travels down the pipe as a sideband and becomes m_axis_tlast.
- FSM:
  - IDLE: s_axis_tready = en. On accept, latch cfg_mode into mode_q and go to RUN; if FRAME_BEATS == 1, go to DRAIN instead.
  - RUN: s_axis_tready = en. Accept of the last beat goes to DRAIN.
  - DRAIN: s_axis_tready = 0. An output handshake with m_axis_tlast goes to IDLE and pulses frame_done in the same cycle.
- cfg_mode is sampled only on the first beat of a frame; changes mid-frame are ignored.
- Arithmetic per lane, unsigned inputs, signed intermediate of width DATA_WIDTH+LOG2+2:
  - mode 0 (sliding average): s = (avg<<LOG2) + new - old + 2^(LOG2-1); new_avg = clamp(s>>>LOG2, 0, 2^DATA_WIDTH-1).
  - mode 1 (EMA average): new_avg = clamp(avg + ((new - avg + 2^(LOG2-1))>>>LOG2)).
  - modes 0 and 1, fused channel: new_fused = clamp(fused + ((new - fused + 2^(FUSE_SHIFT-1))>>>FUSE_SHIFT)).
  - mode 2 (passthrough): new_avg = avg, new_fused = fused.
- Stage split: S1 registers inputs and mode; S2 forms the signed sums; S3 shifts, clamps and packs.
- tlast check, on accept only:
  - s_axis_tlast == 1 when in_cnt != FRAME_BEATS-1, or s_axis_tlast == 0 on the last beat, sets frame_err.
  - Framing always follows the counter, never s_axis_tlast.
- frame_err: set has priority over cfg_err_clr in the same cycle.
- Reset mid-frame discards all in-flight beats; the next accept starts a new frame at in_cnt = 0.

Decomposition:
- Package fusion_pkg:
  - mode encodings MODE_SAVG/MODE_EMA/MODE_PASS
  - state encodings ST_IDLE/ST_RUN/ST_DRAIN
  - function clamp_u(signed value, width)
- One sub-module, fusion_lane_alu, instantiated LANES times via generate. It holds the S2/S3 datapath for one pixel with inputs en and mode.
- FSM, counters and valid/last sideband live in the top.

Test Plan:
- Mode 0, LANES=1, IM 2x2, avg=100, new=120, old=40, fused=50, tready=1 -> new_avg 105, new_fused 59; first output 3 cycles after accept; tlast on beat 4; frame_done pulses once.
- Clamp checks -> mode 0 with avg=0, new=0, old=255 gives new_avg 0; mode 0 with avg=255, new=255, old=0 gives new_avg 255 (no wrap).
- m_axis_tready low for 5 cycles mid-frame -> m_axis_tdata held stable; s_axis_tready drops within 1 cycle; no beat lost or duplicated (scoreboard against golden model).
- s_axis_tlast asserted on beat 2 of 4 -> frame_err = 1; output tlast still on beat 4; cfg_err_clr pulse -> frame_err = 0.
- cfg_mode changed 0→1 mid-frame -> whole frame computed in mode 0; next frame computed in EMA (avg=100, new=120 -> new_avg 101).
- axi_reset asserted during DRAIN with 2 beats in flight -> m_axis_tvalid = 0 immediately; state = IDLE; the next frame is processed correctly from beat 0.
